// File: rtl/mips32_pkg.sv
// -----------------------------------------------------------------------------
// mips32_pkg
//   Constants and types shared by the MIPS32 pipeline and its memory arbiter.
//   Contents:
//     - MEM_AW / DATA_W      : unified memory geometry (1024 x 32)
//     - opcode / funct codes : used by the decode stage
//     - instr_type_e         : coarse instruction class used by hazard logic
//     - TAG_IF / TAG_MEM     : requester encoding carried with each RAM read
//     - gnt_sel_e            : arbitration decision, visible for debug
// -----------------------------------------------------------------------------
package mips32_pkg;

  // Unified instruction/data memory geometry.
  localparam int MEM_AW = 10;
  localparam int DATA_W = 32;

  // Primary opcodes of the supported subset.
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQZ  = 6'h0E;
  localparam logic [5:0] OP_BNEQZ = 6'h0D;
  localparam logic [5:0] OP_HLT   = 6'h3F;

  // Function codes for R-type ALU operations.
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;
  localparam logic [5:0] FN_MUL = 6'h18;

  // Coarse instruction class.
  typedef enum logic [2:0] {
    IT_RR_ALU = 3'd0,
    IT_RM_ALU = 3'd1,
    IT_LOAD   = 3'd2,
    IT_STORE  = 3'd3,
    IT_BRANCH = 3'd4,
    IT_HALT   = 3'd5
  } instr_type_e;

  // Requester tag carried alongside every RAM read.
  localparam logic TAG_IF  = 1'b1;
  localparam logic TAG_MEM = 1'b0;

  // Arbitration decision for the current cycle.
  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_IF   = 2'd1,
    GNT_MEM  = 2'd2
  } gnt_sel_e;

endpackage

// File: rtl/mips_rd_tag_pipe.sv
// -----------------------------------------------------------------------------
// mips_rd_tag_pipe
//   DEPTH-deep shift register of {valid, is_if} read tags. A tag enters in the
//   cycle its RAM command is presented and leaves exactly when the RAM returns
//   the matching read data, so the response can be steered to its owner.
//   Ports:
//     clk1      in   clock, rising edge
//     rst       in   synchronous active-high clear (drops in-flight tags)
//     in_valid  in   tag entering: 1 = a read whose data must be returned
//     in_is_if  in   tag entering: owner (TAG_IF / TAG_MEM)
//     out_valid out  tag leaving this cycle
//     out_is_if out  owner of the leaving tag
// -----------------------------------------------------------------------------
module mips_rd_tag_pipe
  import mips32_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic clk1,
  input  logic rst,
  input  logic in_valid,
  input  logic in_is_if,
  output logic out_valid,
  output logic out_is_if
);

  logic [DEPTH-1:0] valid_sr;
  logic [DEPTH-1:0] is_if_sr;

  always_ff @(posedge clk1) begin
    if (rst) begin
      valid_sr <= '0;
      is_if_sr <= '0;
    end else begin
      for (int i = DEPTH - 1; i > 0; i--) begin
        valid_sr[i] <= valid_sr[i-1];
        is_if_sr[i] <= is_if_sr[i-1];
      end
      valid_sr[0] <= in_valid;
      is_if_sr[0] <= in_is_if;
    end
  end

  assign out_valid = valid_sr[DEPTH-1];
  assign out_is_if = is_if_sr[DEPTH-1];

endmodule

// File: rtl/mips_mem_arbiter.sv
// -----------------------------------------------------------------------------
// mips_mem_arbiter
//   Shares the unified instruction/data RAM between the IF stage (reads only)
//   and the MEM stage (loads and stores). One access is granted per cycle,
//   the RAM command is registered, and read data is routed back to whichever
//   stage issued it. MEM normally wins contention; IF wins once after losing
//   MAX_STARVE contentions in a row.
//
//   Handshake: a requester raises req with its address/data and holds them
//   unchanged until it sees gnt=1 in the same cycle; the access is accepted at
//   that rising edge. Responses (rvalid) are single-cycle pulses, in grant
//   order, and cannot be back-pressured.
//
//   Ports:
//     clk1, rst                  clock, synchronous active-high reset
//     halted                     blocks new IF grants (MEM still served)
//     if_req/if_addr             IF read request
//     if_gnt                     IF accepted this cycle (combinational)
//     if_rvalid/if_rdata         IF instruction return
//     mem_req/mem_we/mem_addr/mem_wdata   MEM load/store request
//     mem_gnt                    MEM accepted this cycle (combinational)
//     mem_rvalid/mem_rdata       MEM load return (never for stores)
//     ram_en/ram_we/ram_addr/ram_wdata    registered RAM command
//     ram_rdata                  RAM read data, RD_LAT cycles after ram_en
// -----------------------------------------------------------------------------
module mips_mem_arbiter
  import mips32_pkg::*;
#(
  parameter int AW         = MEM_AW,
  parameter int RD_LAT     = 1,
  parameter int MAX_STARVE = 4
) (
  input  logic          clk1,
  input  logic          rst,
  input  logic          halted,

  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [31:0]   if_rdata,

  input  logic          mem_req,
  input  logic          mem_we,
  input  logic [AW-1:0] mem_addr,
  input  logic [31:0]   mem_wdata,
  output logic          mem_gnt,
  output logic          mem_rvalid,
  output logic [31:0]   mem_rdata,

  output logic          ram_en,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [31:0]   ram_wdata,
  input  logic [31:0]   ram_rdata
);

  localparam int              SC_W         = $clog2(MAX_STARVE + 1);
  localparam logic [SC_W-1:0] STARVE_LIMIT = SC_W'(MAX_STARVE);

  // Consecutive contentions IF has lost to MEM.
  logic [SC_W-1:0] starve_cnt;
  logic            if_eligible;
  logic            if_starved;
  gnt_sel_e        gnt_sel;

  // Owner of the command currently on the RAM port.
  logic            ram_is_if;
  logic            tag_valid;
  logic            tag_is_if;

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  assign if_eligible = if_req & ~halted;
  assign if_starved  = (starve_cnt == STARVE_LIMIT);

  always_comb begin
    gnt_sel = GNT_NONE;
    if (rst) begin
      // Reset overrides any pending request in this cycle.
      gnt_sel = GNT_NONE;
    end else if (if_eligible && if_starved) begin
      gnt_sel = GNT_IF;
    end else if (mem_req) begin
      // MEM holds the older instruction, so it normally goes first.
      gnt_sel = GNT_MEM;
    end else if (if_eligible) begin
      gnt_sel = GNT_IF;
    end
  end

  assign if_gnt  = (gnt_sel == GNT_IF);
  assign mem_gnt = (gnt_sel == GNT_MEM);

  // ---------------------------------------------------------------------------
  // Starvation counter: frozen while halted so a drain does not distort it.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk1) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (!halted) begin
      if (!if_req || if_gnt) begin
        starve_cnt <= '0;
      end else if (mem_gnt && !if_starved) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registered RAM command. Address and write data simply hold when idle.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk1) begin
    if (rst) begin
      ram_en    <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      ram_is_if <= TAG_MEM;
    end else begin
      ram_en <= 1'b0;
      ram_we <= 1'b0;
      if (if_gnt) begin
        ram_en    <= 1'b1;
        ram_addr  <= if_addr;
        ram_is_if <= TAG_IF;
      end else if (mem_gnt) begin
        ram_en    <= 1'b1;
        ram_we    <= mem_we;
        ram_addr  <= mem_addr;
        ram_wdata <= mem_wdata;
        ram_is_if <= TAG_MEM;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read tags travel alongside the RAM latency; stores carry valid=0.
  // ---------------------------------------------------------------------------
  mips_rd_tag_pipe #(
    .DEPTH (RD_LAT)
  ) u_tag_pipe (
    .clk1      (clk1),
    .rst       (rst),
    .in_valid  (ram_en & ~ram_we),
    .in_is_if  (ram_is_if),
    .out_valid (tag_valid),
    .out_is_if (tag_is_if)
  );

  // ---------------------------------------------------------------------------
  // Response demux: capture RAM data for the tag's owner; rdata holds between
  // pulses so the consuming stage may sample it late.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk1) begin
    if (rst) begin
      if_rvalid  <= 1'b0;
      if_rdata   <= '0;
      mem_rvalid <= 1'b0;
      mem_rdata  <= '0;
    end else begin
      if_rvalid  <= tag_valid && (tag_is_if == TAG_IF);
      mem_rvalid <= tag_valid && (tag_is_if == TAG_MEM);
      if (tag_valid && (tag_is_if == TAG_IF)) begin
        if_rdata <= ram_rdata;
      end
      if (tag_valid && (tag_is_if == TAG_MEM)) begin
        mem_rdata <= ram_rdata;
      end
    end
  end

endmodule
